// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//   - op-code localparams
//   - flag bit indices inside the 5-bit {N,Z,C,V,Q} flag vector
//   - FSM state type
//   - sat_add: signed-overflow / clamp-direction detection for a two's-complement add
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_ORR  = 4'b0011;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_MLA  = 4'b0101;
    localparam logic [3:0] OP_EOR  = 4'b0110;
    localparam logic [3:0] OP_MVN  = 4'b0111;
    localparam logic [3:0] OP_QADD = 4'b1000;
    localparam logic [3:0] OP_QSUB = 4'b1001;

    localparam int FLG_N = 4;
    localparam int FLG_Z = 3;
    localparam int FLG_C = 2;
    localparam int FLG_V = 1;
    localparam int FLG_Q = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic ovf;  // signed overflow occurred
        logic neg;  // clamp towards the most negative value
    } sat_t;

    // Works on sign bits only so it is width independent. For a subtract,
    // pass the sign of the inverted second operand (a + ~b + 1).
    function automatic sat_t sat_add(input logic a_msb, input logic b_msb, input logic sum_msb);
        sat_t r;
        r.ovf = (a_msb == b_msb) && (sum_msb != a_msb);
        r.neg = a_msb;
        return r;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, MUL_STEP multiplier bits per cycle.
// Ports:
//   clk, reset (async active-low)
//   start      - load operands (acc = mla ? c : 0, mcand = a, mplier = b)
//   mla, a, b, c
//   done       - high in the cycle whose rising edge retires the last step
//   product    - accumulator value after the current step (valid with done)
module alu_mul_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mla,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int N  = WIDTH / MUL_STEP;
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [CW-1:0]    cnt_reg;
    logic             busy_reg;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] pp_terms [MUL_STEP];

    // One gated, shifted copy of mcand per retired multiplier bit.
    generate
        for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_pp
            assign pp_terms[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
        end
    endgenerate

    always_comb begin
        acc_next = acc_reg;
        for (int i = 0; i < MUL_STEP; i++) begin
            acc_next = acc_next + pp_terms[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
        end else if (start) begin
            acc_reg    <= mla ? c : '0;
            mcand_reg  <= a;
            mplier_reg <= b;
            cnt_reg    <= CW'(N - 1);
            busy_reg   <= 1'b1;
        end else if (busy_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << MUL_STEP;
            mplier_reg <= mplier_reg >> MUL_STEP;
            if (cnt_reg == '0) begin
                busy_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

    assign done    = busy_reg & (cnt_reg == '0);
    assign product = acc_next;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake and sticky saturation bit.
// Ports:
//   clk, reset (async active-low)
//   in_valid/in_ready, a, b, c, op     - operation request
//   out_valid/out_ready, result, flags - registered result and {N,Z,C,V,Q}
//   q_sticky, q_clear                  - OR of Q over consumed results, sync clear
import alu_pkg::*;

module alu_mc #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags,
    output logic             q_sticky,
    input  logic             q_clear
);
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_reg, state_next;
    logic             accept, is_mul, mul_start, mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] result_reg;
    logic [4:0]       flags_reg;
    logic             q_sticky_reg;

    logic [WIDTH:0]   sum_add, sum_sub;
    sat_t             ov_add, ov_sub;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_q;
    logic [4:0]       alu_flags;

    assign is_mul = (op == OP_MUL) || (op == OP_MLA);
    assign accept = in_valid & in_ready;

    // ---------------- single-cycle datapath ----------------
    assign sum_add = {1'b0, a} + {1'b0, b};
    assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign ov_add  = sat_add(a[WIDTH-1], b[WIDTH-1], sum_add[WIDTH-1]);
    assign ov_sub  = sat_add(a[WIDTH-1], ~b[WIDTH-1], sum_sub[WIDTH-1]);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_q   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum_add[WIDTH-1:0];
                alu_c   = sum_add[WIDTH];
                alu_v   = ov_add.ovf;
            end
            OP_SUB: begin
                alu_res = sum_sub[WIDTH-1:0];
                alu_c   = sum_sub[WIDTH];
                alu_v   = ov_sub.ovf;
            end
            OP_AND: alu_res = a & b;
            OP_ORR: alu_res = a | b;
            OP_EOR: alu_res = a ^ b;
            OP_MVN: alu_res = ~b;
            OP_QADD: begin
                alu_res = ov_add.ovf ? (ov_add.neg ? SAT_MIN : SAT_MAX) : sum_add[WIDTH-1:0];
                alu_q   = ov_add.ovf;
            end
            OP_QSUB: begin
                alu_res = ov_sub.ovf ? (ov_sub.neg ? SAT_MIN : SAT_MAX) : sum_sub[WIDTH-1:0];
                alu_q   = ov_sub.ovf;
            end
            default: alu_res = '0;  // undefined ops: result 0, so flags read 01000
        endcase
        alu_flags        = '0;
        alu_flags[FLG_N] = alu_res[WIDTH-1];
        alu_flags[FLG_Z] = (alu_res == '0);
        alu_flags[FLG_C] = alu_c;
        alu_flags[FLG_V] = alu_v;
        alu_flags[FLG_Q] = alu_q;
    end

    // ---------------- multiplier ----------------
    alu_mul_iter #(
        .WIDTH    (WIDTH),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .mla     (op == OP_MLA),
        .a       (a),
        .b       (b),
        .c       (c),
        .done    (mul_done),
        .product (mul_product)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    state_next = is_mul ? ST_MUL : ST_HOLD;
                end else if (state_reg == ST_HOLD && out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_next = ST_HOLD;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == ST_IDLE) || ((state_reg == ST_HOLD) && out_ready);
        out_valid = (state_reg == ST_HOLD);
        mul_start = accept & is_mul;
    end

    // ---------------- result / flag / sticky registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_reg   <= '0;
            flags_reg    <= '0;
            q_sticky_reg <= 1'b0;
        end else begin
            if (accept && !is_mul) begin
                result_reg <= alu_res;
                flags_reg  <= alu_flags;
            end else if (mul_done) begin
                result_reg <= mul_product;
                flags_reg  <= {mul_product[WIDTH-1], (mul_product == '0), 3'b000};
            end
            // Setting on consume takes priority over a simultaneous clear.
            if (out_valid && out_ready && flags_reg[FLG_Q]) begin
                q_sticky_reg <= 1'b1;
            end else if (q_clear) begin
                q_sticky_reg <= 1'b0;
            end
        end
    end

    assign result   = result_reg;
    assign flags    = flags_reg;
    assign q_sticky = q_sticky_reg;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, q_clear = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = '0, b = '0, c = '0;
    logic        in_ready, out_valid, q_sticky;
    logic [31:0] result;
    logic [4:0]  flags;

    logic        in_valid16 = 1'b0, out_ready16 = 1'b0, q_clear16 = 1'b0;
    logic [3:0]  op16 = 4'd0;
    logic [15:0] a16 = '0, b16 = '0, c16 = '0;
    logic        in_ready16, out_valid16, q_sticky16;
    logic [15:0] result16;
    logic [4:0]  flags16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_mc u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .q_sticky(q_sticky), .q_clear(q_clear)
    );

    alu_mc #(.WIDTH(16), .MUL_STEP(4)) u_dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .c(c16), .op(op16), .out_valid(out_valid16), .out_ready(out_ready16),
        .result(result16), .flags(flags16), .q_sticky(q_sticky16), .q_clear(q_clear16)
    );

    // Present one request for one cycle; returns at the negedge after the accept edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        @(negedge clk);
        op = o; a = x; b = y; c = z; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL reset_flags got %b want 00000", flags); end
        checks++; if (q_sticky !== 1'b0) begin errors++; $display("FAIL reset_q_sticky got %b want 0", q_sticky); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        $display("reset: done");
    endtask

    task automatic test_logic_add();
        issue(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency out_valid got %b want 1", out_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL add_wrap_result got %h want 00000000", result); end
        checks++; if (flags !== 5'b01100) begin errors++; $display("FAIL add_wrap_flags got %b want 01100", flags); end
        $display("ADD ffffffff+1 -> %h flags %b", result, flags);
        consume();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_consume out_valid got %b want 0", out_valid); end

        issue(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0);
        checks++; if ({result, flags} !== {32'h8000_0000, 5'b10010}) begin errors++; $display("FAIL add_ovf got %h/%b want 80000000/10010", result, flags); end
        $display("ADD 7fffffff+1 -> %h flags %b", result, flags);
        consume();

        issue(4'b0111, 32'h1234_5678, 32'h0000_0000, 32'h0);
        checks++; if ({result, flags} !== {32'hFFFF_FFFF, 5'b10000}) begin errors++; $display("FAIL mvn got %h/%b want ffffffff/10000", result, flags); end
        $display("MVN 0 -> %h flags %b", result, flags);
        consume();

        issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0);
        checks++; if ({result, flags} !== {32'h0, 5'b01000}) begin errors++; $display("FAIL undef_op got %h/%b want 00000000/01000", result, flags); end
        $display("OP 1111 -> %h flags %b", result, flags);
        consume();
    endtask

    task automatic test_sat();
        issue(4'b1000, 32'h7FFF_FFF0, 32'h0000_0020, 32'h0);
        checks++; if ({result, flags} !== {32'h7FFF_FFFF, 5'b00001}) begin errors++; $display("FAIL qadd_clamp got %h/%b want 7fffffff/00001", result, flags); end
        checks++; if (q_sticky !== 1'b0) begin errors++; $display("FAIL q_before_consume got %b want 0", q_sticky); end
        $display("QADD 7ffffff0+20 -> %h flags %b", result, flags);
        out_ready = 1'b1; q_clear = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; q_clear = 1'b0;
        checks++; if (q_sticky !== 1'b1) begin errors++; $display("FAIL q_set_wins got %b want 1", q_sticky); end
        q_clear = 1'b1;
        @(negedge clk);
        q_clear = 1'b0;
        checks++; if (q_sticky !== 1'b0) begin errors++; $display("FAIL q_clear got %b want 0", q_sticky); end

        issue(4'b1001, 32'h8000_0000, 32'h0000_0001, 32'h0);
        checks++; if ({result, flags} !== {32'h8000_0000, 5'b10001}) begin errors++; $display("FAIL qsub_clamp got %h/%b want 80000000/10001", result, flags); end
        $display("QSUB 80000000-1 -> %h flags %b", result, flags);
        consume();
        checks++; if (q_sticky !== 1'b1) begin errors++; $display("FAIL q_after_qsub got %b want 1", q_sticky); end

        issue(4'b1000, 32'h0000_0001, 32'h0000_0002, 32'h0);
        checks++; if ({result, flags} !== {32'h0000_0003, 5'b00000}) begin errors++; $display("FAIL qadd_noclamp got %h/%b want 00000003/00000", result, flags); end
        $display("QADD 1+2 -> %h flags %b", result, flags);
        consume();
    endtask

    task automatic test_mul();
        logic [31:0] want_r [2];
        logic [4:0]  want_f [2];
        logic [3:0]  ops    [2];
        logic [31:0] va [2], vb [2], vc [2];
        ops[0] = 4'b0101; va[0] = 32'h0001_0001; vb[0] = 32'h3; vc[0] = 32'h5; want_r[0] = 32'h0003_0008; want_f[0] = 5'b00000;
        ops[1] = 4'b0100; va[1] = 32'h0001_0000; vb[1] = 32'h0001_0000; vc[1] = 32'h7; want_r[1] = 32'h0; want_f[1] = 5'b01000;
        for (int t = 0; t < 2; t++) begin
            issue(ops[t], va[t], vb[t], vc[t]);
            a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; c = 32'h1;
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                    errors++; $display("FAIL mul%0d_busy cyc %0d got valid %b ready %b want 0 0", t, i, out_valid, in_ready);
                end
                @(negedge clk);
            end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mul%0d_latency out_valid got %b want 1", t, out_valid); end
            checks++; if ({result, flags} !== {want_r[t], want_f[t]}) begin errors++; $display("FAIL mul%0d_result got %h/%b want %h/%b", t, result, flags, want_r[t], want_f[t]); end
            $display("MUL/MLA op %b -> %h flags %b", ops[t], result, flags);
            consume();
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        @(negedge clk);
        op = 4'b0000; a = 32'd3; b = 32'd4; in_valid = 1'b1;
        @(negedge clk);
        checks++; if ({out_valid, in_ready, result, flags} !== {2'b11, 32'h7, 5'b00000}) begin errors++; $display("FAIL b2b_add got v%b r%b %h/%b want v1 r1 00000007/00000", out_valid, in_ready, result, flags); end
        $display("B2B ADD -> %h flags %b", result, flags);
        op = 4'b0001; a = 32'd10; b = 32'd12;
        @(negedge clk);
        checks++; if ({out_valid, result, flags} !== {1'b1, 32'hFFFF_FFFE, 5'b10000}) begin errors++; $display("FAIL b2b_sub got v%b %h/%b want v1 fffffffe/10000", out_valid, result, flags); end
        $display("B2B SUB -> %h flags %b", result, flags);
        op = 4'b0010; a = 32'h0000_F0F0; b = 32'h0000_FF00;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if ({out_valid, result, flags} !== {1'b1, 32'h0000_F000, 5'b00000}) begin errors++; $display("FAIL b2b_and got v%b %h/%b want v1 0000f000/00000", out_valid, result, flags); end
        $display("B2B AND -> %h flags %b", result, flags);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain out_valid got %b want 0", out_valid); end

        out_ready = 1'b0;
        issue(4'b0001, 32'd5, 32'd3, 32'h0);
        op = 4'b0000; a = 32'hFFFF_FFFF; b = 32'h0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({out_valid, in_ready, result, flags} !== {2'b10, 32'h2, 5'b00100}) begin
                errors++; $display("FAIL hold cyc %0d got v%b r%b %h/%b want v1 r0 00000002/00100", i, out_valid, in_ready, result, flags);
            end
            @(negedge clk);
        end
        $display("HOLD SUB 5-3 -> %h flags %b", result, flags);
        consume();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_mul();
        issue(4'b0100, 32'd3, 32'd5, 32'h0);
        repeat (6) @(negedge clk);
        checks++; if ({in_ready, q_sticky} !== 2'b01) begin errors++; $display("FAIL pre_reset got r%b q%b want r0 q1", in_ready, q_sticky); end
        reset = 1'b0;
        #1;
        checks++; if ({out_valid, q_sticky, result, flags} !== {2'b00, 32'h0, 5'b00000}) begin errors++; $display("FAIL mid_mul_reset got v%b q%b %h/%b want v0 q0 00000000/00000", out_valid, q_sticky, result, flags); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", in_ready); end
        issue(4'b0001, 32'd5, 32'd7, 32'h0);
        checks++; if ({out_valid, result, flags} !== {1'b1, 32'hFFFF_FFFE, 5'b10000}) begin errors++; $display("FAIL post_reset_sub got v%b %h/%b want v1 fffffffe/10000", out_valid, result, flags); end
        $display("SUB 5-7 after reset -> %h flags %b", result, flags);
        consume();
    endtask

    task automatic test_w16();
        logic [3:0]  ops [5];
        logic [15:0] va [5], vb [5], vc [5], want_r [5];
        logic [4:0]  want_f [5];
        ops[0] = 4'b0100; va[0] = 16'h1234; vb[0] = 16'h0005; vc[0] = 16'h0;    want_r[0] = 16'h5B04; want_f[0] = 5'b00000;
        ops[1] = 4'b0101; va[1] = 16'hFFFF; vb[1] = 16'hFFFF; vc[1] = 16'h0002; want_r[1] = 16'h0003; want_f[1] = 5'b00000;
        ops[2] = 4'b0100; va[2] = 16'h0100; vb[2] = 16'h0100; vc[2] = 16'h1111; want_r[2] = 16'h0000; want_f[2] = 5'b01000;
        ops[3] = 4'b0101; va[3] = 16'h00FF; vb[3] = 16'h0081; vc[3] = 16'h8000; want_r[3] = 16'h007F; want_f[3] = 5'b00000;
        ops[4] = 4'b0100; va[4] = 16'h8000; vb[4] = 16'h0001; vc[4] = 16'h0;    want_r[4] = 16'h8000; want_f[4] = 5'b10000;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            op16 = ops[t]; a16 = va[t]; b16 = vb[t]; c16 = vc[t]; in_valid16 = 1'b1;
            @(negedge clk);
            in_valid16 = 1'b0;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (out_valid16 !== 1'b0) begin errors++; $display("FAIL w16_%0d_early cyc %0d out_valid got %b want 0", t, i, out_valid16); end
                @(negedge clk);
            end
            checks++;
            if ({out_valid16, result16, flags16} !== {1'b1, want_r[t], want_f[t]}) begin
                errors++; $display("FAIL w16_%0d got v%b %h/%b want v1 %h/%b", t, out_valid16, result16, flags16, want_r[t], want_f[t]);
            end
            $display("W16 op %b %h,%h,%h -> %h flags %b", ops[t], va[t], vb[t], vc[t], result16, flags16);
            out_ready16 = 1'b1;
            @(negedge clk);
            out_ready16 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_logic_add();
        test_sat();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        test_w16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
